// File: rtl/mips_seq_pkg.sv
// Shared types and opcode constants for the MIPS multi-cycle stage sequencer
// and related control logic.
`timescale 1ns/1ps
package mips_seq_pkg;

  // One-hot encoding so each stage enable is a single state bit; IDLE is all-zero.
  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    ID   = 4'b0001,
    EX   = 4'b0010,
    MEM  = 4'b0100,
    WB   = 4'b1000
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational opcode classifier: maps the primary opcode field to the class
// that decides which stages an instruction visits.
`timescale 1ns/1ps
module mips_op_classify
  import mips_seq_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_e  op_class_o
);

  // Opcode field to stage-path class; anything unrecognised is illegal.
  always_comb begin
    op_class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_RTYPE, OP_ADDI: op_class_o = CLS_R;
      OP_LW:             op_class_o = CLS_LOAD;
      OP_SW:             op_class_o = CLS_STORE;
      OP_BEQ:            op_class_o = CLS_BRANCH;
      default:           op_class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_stage_sequencer.sv
// Multi-cycle stage sequencer: accepts one instruction, holds it in the IR,
// walks it through ID/EX/MEM/WB as its class requires, and gates the raw
// control-path write/read strobes to their own stage.
`timescale 1ns/1ps
module mips_stage_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instrword,
  output logic             instr_ready,
  output logic [31:0]      ir,
  input  logic             ctl_regwrite,
  input  logic             ctl_memread,
  input  logic             ctl_memwrite,
  input  logic             mem_ready,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             retire,
  output logic             illegal,
  output logic             mem_fault,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       wait_inc;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c, illegal_c, fault_c;
  op_class_e        op_class;

  mips_op_classify u_classify (
    .opcode_i   (ir_q[31:26]),
    .op_class_o (op_class)
  );

  assign wait_inc = wait_q + 8'd1;

  // Next-state, IR load, MEM wait counting and the per-cycle event pulses.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    fault_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instrword;
          state_d = ID;
        end
      end
      ID: begin
        if (op_class == CLS_ILLEGAL) begin
          illegal_c = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = EX;
        end
      end
      EX: begin
        case (op_class)
          CLS_BRANCH: begin
            retire_c = 1'b1;
            state_d  = IDLE;
          end
          CLS_LOAD, CLS_STORE: begin
            wait_d  = '0;
            state_d = MEM;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        // mem_ready is tested before the limit so a completion on the
        // would-be timeout cycle is still a success.
        if (mem_ready) begin
          if (op_class == CLS_STORE) begin
            retire_c = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WB;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT) begin
            fault_c = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WB: begin
        retire_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    retired_d = retired_q + CNT_W'(retire_c);
  end

  // State, instruction register and counters; reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign id_en       = (state_q == ID);
  assign ex_en       = (state_q == EX);
  assign mem_en      = (state_q == MEM);
  assign wb_en       = (state_q == WB);
  assign reg_write   = ctl_regwrite & wb_en;
  assign mem_read    = ctl_memread  & mem_en;
  assign mem_write   = ctl_memwrite & mem_en;
  assign retire      = retire_c;
  assign illegal     = illegal_c;
  assign mem_fault   = fault_c;
  assign ir          = ir_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Directed bench for mips_stage_sequencer: one task per scenario, each with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_mips_stage_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instrword = '0;
  logic        ctl_regwrite = 1'b0, ctl_memread = 1'b0, ctl_memwrite = 1'b0;
  logic        mem_ready = 1'b0;
  logic        instr_ready;
  logic [31:0] ir;
  logic        id_en, ex_en, mem_en, wb_en, reg_write, mem_read, mem_write;
  logic        retire, illegal, mem_fault;
  logic [15:0] retired_cnt;

  logic        valid_b = 1'b0;
  logic [31:0] word_b = '0;
  logic        ready_b;
  logic [31:0] ir_b;
  logic        id_b, ex_b, mem_b, wb_b, rw_b, mr_b, mw_b, ret_b, ill_b, flt_b;
  logic [3:0]  cnt_b;

  int vec = 0;
  int err = 0;

  always #5 clock = ~clock;

  mips_stage_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instrword(instrword),
    .instr_ready(instr_ready), .ir(ir), .ctl_regwrite(ctl_regwrite),
    .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite), .mem_ready(mem_ready),
    .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .retire(retire), .illegal(illegal), .mem_fault(mem_fault), .retired_cnt(retired_cnt)
  );

  mips_stage_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) dut_b (
    .clock(clock), .reset(reset), .instr_valid(valid_b), .instrword(word_b),
    .instr_ready(ready_b), .ir(ir_b), .ctl_regwrite(ctl_regwrite),
    .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite), .mem_ready(mem_ready),
    .id_en(id_b), .ex_en(ex_b), .mem_en(mem_b), .wb_en(wb_b),
    .reg_write(rw_b), .mem_read(mr_b), .mem_write(mw_b),
    .retire(ret_b), .illegal(ill_b), .mem_fault(flt_b), .retired_cnt(cnt_b)
  );

  // Observation accumulators filled by observe().
  int n_id, n_ex, n_mem, n_wb, n_rw, n_rw_bad, n_mr, n_mr_bad, n_mw;
  int n_ret, r_wb, r_mem, r_ex, n_ill, ill_id, n_flt, flt_idx, first_rdy;
  logic rdy_glitch = 1'b0;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Present one word in IDLE and return just after the accept edge.
  task automatic accept(input logic [31:0] w);
    instr_valid = 1'b1;
    instrword   = w;
    tick();
    instr_valid = 1'b0;
  endtask

  // Run ncyc cycles after an accept, answering mem_ready on MEM cycle wait_k+1.
  task automatic observe(input int ncyc, input int wait_k);
    int seen;
    seen = 0;
    n_id = 0; n_ex = 0; n_mem = 0; n_wb = 0; n_rw = 0; n_rw_bad = 0;
    n_mr = 0; n_mr_bad = 0; n_mw = 0; n_ret = 0; r_wb = 0; r_mem = 0; r_ex = 0;
    n_ill = 0; ill_id = 0; n_flt = 0; flt_idx = -1; first_rdy = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (mem_en) seen++;
      mem_ready = mem_en ? (seen > wait_k) : rdy_glitch;
      #1;
      n_id  += int'(id_en);  n_ex += int'(ex_en);
      n_mem += int'(mem_en); n_wb += int'(wb_en);
      n_rw  += int'(reg_write); n_mr += int'(mem_read); n_mw += int'(mem_write);
      if (reg_write && !wb_en) n_rw_bad++;
      if (mem_read && !mem_en) n_mr_bad++;
      n_ret += int'(retire);
      if (retire && wb_en)  r_wb++;
      if (retire && mem_en) r_mem++;
      if (retire && ex_en)  r_ex++;
      n_ill += int'(illegal);
      if (illegal && id_en) ill_id++;
      if (mem_fault) begin n_flt++; flt_idx = seen; end
      if (instr_ready && first_rdy < 0) first_rdy = c + 1;
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec++; if (instr_ready !== 1'b1) begin err++; $display("FAIL rst_ready got %b want 1", instr_ready); end
    vec++; if ({ir, retired_cnt} !== 48'h0) begin err++; $display("FAIL rst_regs got ir=%h cnt=%0d want 0", ir, retired_cnt); end
    vec++; if ({id_en, ex_en, mem_en, wb_en, reg_write, mem_read, mem_write, retire, illegal, mem_fault} !== 10'b0)
      begin err++; $display("FAIL rst_outs got nonzero enable/pulse want all 0"); end
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    vec++; if (instr_ready !== 1'b1 || id_en !== 1'b0) begin err++; $display("FAIL rst_release got rdy=%b id=%b want 1/0", instr_ready, id_en); end
  endtask

  task automatic test_rtype();
    ctl_regwrite = 1'b1; ctl_memread = 1'b1; ctl_memwrite = 1'b1;
    accept(32'h012A4020);
    vec++; if (ir !== 32'h012A4020) begin err++; $display("FAIL rt_ir got %h want 012a4020", ir); end
    observe(6, 0);
    vec++; if ({n_id, n_ex, n_wb} !== {32'd1, 32'd1, 32'd1}) begin err++; $display("FAIL rt_stages got id=%0d ex=%0d wb=%0d want 1 1 1", n_id, n_ex, n_wb); end
    vec++; if (n_mem !== 0 || n_mr !== 0 || n_mw !== 0) begin err++; $display("FAIL rt_nomem got mem=%0d mr=%0d mw=%0d want 0", n_mem, n_mr, n_mw); end
    vec++; if (n_rw !== 1 || n_rw_bad !== 0) begin err++; $display("FAIL rt_regwrite got %0d (outside wb %0d) want 1/0", n_rw, n_rw_bad); end
    vec++; if (n_ret !== 1 || r_wb !== 1) begin err++; $display("FAIL rt_retire got %0d in_wb=%0d want 1/1", n_ret, r_wb); end
    vec++; if (first_rdy !== 4) begin err++; $display("FAIL rt_latency got %0d want 4", first_rdy); end
    vec++; if (retired_cnt !== 16'd1) begin err++; $display("FAIL rt_cnt got %0d want 1", retired_cnt); end
  endtask

  task automatic test_load_wait();
    ctl_regwrite = 1'b1; ctl_memread = 1'b1; ctl_memwrite = 1'b0; rdy_glitch = 1'b1;
    accept(32'h8D090004);
    observe(10, 3);
    rdy_glitch = 1'b0;
    vec++; if (n_mem !== 4) begin err++; $display("FAIL lw_mem_cycles got %0d want 4", n_mem); end
    vec++; if (n_mr !== 4 || n_mr_bad !== 0) begin err++; $display("FAIL lw_memread got %0d (outside %0d) want 4/0", n_mr, n_mr_bad); end
    vec++; if (n_wb !== 1 || n_rw !== 1 || n_rw_bad !== 0) begin err++; $display("FAIL lw_wb got wb=%0d rw=%0d bad=%0d want 1 1 0", n_wb, n_rw, n_rw_bad); end
    vec++; if (n_ret !== 1 || r_wb !== 1) begin err++; $display("FAIL lw_retire got %0d in_wb=%0d want 1/1", n_ret, r_wb); end
    vec++; if (first_rdy !== 8) begin err++; $display("FAIL lw_latency got %0d want 8", first_rdy); end
    vec++; if (retired_cnt !== 16'd2) begin err++; $display("FAIL lw_cnt got %0d want 2", retired_cnt); end
  endtask

  task automatic test_store_timeout();
    ctl_regwrite = 1'b1; ctl_memread = 1'b0; ctl_memwrite = 1'b1;
    accept(32'hAD090004);
    observe(22, 1000);
    vec++; if (n_mem !== 15) begin err++; $display("FAIL swto_mem_cycles got %0d want 15", n_mem); end
    vec++; if (n_flt !== 1 || flt_idx !== 15) begin err++; $display("FAIL swto_fault got %0d at mem cycle %0d want 1 at 15", n_flt, flt_idx); end
    vec++; if (n_wb !== 0 || n_rw !== 0 || n_ret !== 0) begin err++; $display("FAIL swto_nowb got wb=%0d rw=%0d ret=%0d want 0", n_wb, n_rw, n_ret); end
    vec++; if (n_mw !== 15) begin err++; $display("FAIL swto_memwrite got %0d want 15", n_mw); end
    vec++; if (first_rdy !== 18) begin err++; $display("FAIL swto_idle got %0d want 18", first_rdy); end
    vec++; if (retired_cnt !== 16'd2) begin err++; $display("FAIL swto_cnt got %0d want 2", retired_cnt); end
  endtask

  task automatic test_branch_illegal();
    ctl_regwrite = 1'b0; ctl_memread = 1'b0; ctl_memwrite = 1'b0;
    accept(32'h11090002);
    observe(6, 0);
    vec++; if (n_ex !== 1 || r_ex !== 1 || n_ret !== 1) begin err++; $display("FAIL beq_retire got ex=%0d in_ex=%0d ret=%0d want 1 1 1", n_ex, r_ex, n_ret); end
    vec++; if (n_mem !== 0 || n_wb !== 0) begin err++; $display("FAIL beq_nomemwb got mem=%0d wb=%0d want 0", n_mem, n_wb); end
    vec++; if (first_rdy !== 3) begin err++; $display("FAIL beq_latency got %0d want 3", first_rdy); end
    ctl_regwrite = 1'b1;
    accept(32'hFC000000);
    observe(5, 0);
    vec++; if (n_id !== 1 || n_ill !== 1 || ill_id !== 1) begin err++; $display("FAIL ill_pulse got id=%0d ill=%0d in_id=%0d want 1 1 1", n_id, n_ill, ill_id); end
    vec++; if (n_ex !== 0 || n_ret !== 0 || n_rw !== 0) begin err++; $display("FAIL ill_noex got ex=%0d ret=%0d rw=%0d want 0", n_ex, n_ret, n_rw); end
    vec++; if (first_rdy !== 2) begin err++; $display("FAIL ill_idle got %0d want 2", first_rdy); end
    vec++; if (retired_cnt !== 16'd3) begin err++; $display("FAIL beqill_cnt got %0d want 3", retired_cnt); end
  endtask

  task automatic test_store_ok();
    ctl_regwrite = 1'b0; ctl_memread = 1'b0; ctl_memwrite = 1'b1;
    accept(32'hAD090004);
    observe(8, 2);
    vec++; if (n_mem !== 3 || n_mw !== 3) begin err++; $display("FAIL sw_mem got mem=%0d mw=%0d want 3 3", n_mem, n_mw); end
    vec++; if (n_ret !== 1 || r_mem !== 1 || n_wb !== 0) begin err++; $display("FAIL sw_retire got ret=%0d in_mem=%0d wb=%0d want 1 1 0", n_ret, r_mem, n_wb); end
    vec++; if (first_rdy !== 6) begin err++; $display("FAIL sw_latency got %0d want 6", first_rdy); end
    // Ready on the 15th MEM cycle, exactly where the timeout would fire.
    accept(32'hAD090004);
    observe(20, 14);
    vec++; if (n_flt !== 0 || n_ret !== 1 || r_mem !== 1) begin err++; $display("FAIL sw_readywins got flt=%0d ret=%0d want 0 1", n_flt, n_ret); end
    vec++; if (n_mem !== 15 || first_rdy !== 18) begin err++; $display("FAIL sw_edge got mem=%0d rdy=%0d want 15 18", n_mem, first_rdy); end
    vec++; if (retired_cnt !== 16'd5) begin err++; $display("FAIL sw_cnt got %0d want 5", retired_cnt); end
  endtask

  task automatic test_reset_mid_load();
    int n_rw_rst;
    ctl_regwrite = 1'b1; ctl_memread = 1'b1; ctl_memwrite = 1'b0;
    mem_ready = 1'b0;
    accept(32'h8D090004);
    tick(); tick(); tick();
    vec++; if (mem_en !== 1'b1) begin err++; $display("FAIL rml_inmem got %b want 1", mem_en); end
    #2;
    reset = 1'b0;
    #1;
    vec++; if ({id_en, ex_en, mem_en, wb_en, reg_write, mem_read, mem_write, retire, illegal, mem_fault} !== 10'b0)
      begin err++; $display("FAIL rml_async got nonzero enable/pulse want all 0"); end
    vec++; if (ir !== 32'h0 || retired_cnt !== 16'd0 || instr_ready !== 1'b1) begin err++; $display("FAIL rml_regs got ir=%h cnt=%0d rdy=%b want 0 0 1", ir, retired_cnt, instr_ready); end
    n_rw_rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_rw_rst += int'(reg_write) + int'(retire);
    end
    reset = 1'b1;
    tick();
    n_rw_rst += int'(reg_write) + int'(retire);
    vec++; if (n_rw_rst !== 0) begin err++; $display("FAIL rml_nowrite got %0d want 0", n_rw_rst); end
    vec++; if (instr_ready !== 1'b1) begin err++; $display("FAIL rml_ready got %b want 1", instr_ready); end
    accept(32'h012A4020);
    observe(6, 0);
    vec++; if (n_ret !== 1 || n_rw !== 1 || first_rdy !== 4) begin err++; $display("FAIL rml_add got ret=%0d rw=%0d rdy=%0d want 1 1 4", n_ret, n_rw, first_rdy); end
    vec++; if (retired_cnt !== 16'd1) begin err++; $display("FAIL rml_cnt got %0d want 1", retired_cnt); end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_rb, last, bad_gap;
    logic [3:0] cnt_at_60;
    n_acc = 0; n_rb = 0; last = -1; bad_gap = 0; cnt_at_60 = 4'hx;
    word_b  = 32'h21080001;
    valid_b = 1'b1;
    for (int c = 0; c <= 64; c++) begin
      if (ready_b) begin
        if (valid_b) n_acc++;
        if (last >= 0 && c - last != 4) bad_gap++;
        last = c;
      end
      n_rb += int'(ret_b);
      if (c == 60) cnt_at_60 = cnt_b;
      if (c == 64) begin
        vec++; if (cnt_b !== 4'd0) begin err++; $display("FAIL b2b_wrap got %0d want 0", cnt_b); end
      end
      if (c == 63) valid_b = 1'b0;
      tick();
    end
    vec++; if (n_acc !== 16 || bad_gap !== 0) begin err++; $display("FAIL b2b_accepts got %0d bad_gaps=%0d want 16 0", n_acc, bad_gap); end
    vec++; if (n_rb !== 16) begin err++; $display("FAIL b2b_retires got %0d want 16", n_rb); end
    vec++; if (cnt_at_60 !== 4'd15) begin err++; $display("FAIL b2b_cnt15 got %0d want 15", cnt_at_60); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_timeout();
    test_branch_illegal();
    test_store_ok();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
